// File: rtl/rega_pkg.sv
// Shared types and helpers for the irrigation controller (controle_rega).
// Holds the FSM state encoding, the tank-level sensor codes and small
// constant functions used for validity checks and counter sizing.
package rega_pkg;

  // FSM states; the numeric values are visible on the Estado port.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENCHE = 3'd1,
    REGA  = 3'd2,
    PAUSA = 3'd3,
    ERRO  = 3'd4
  } estado_t;

  // Filtered sensor codes, bit order {H, M, L}.
  localparam logic [2:0] NV_CRITICO = 3'b000;
  localparam logic [2:0] NV_BAIXO   = 3'b001;
  localparam logic [2:0] NV_MEDIO   = 3'b011;
  localparam logic [2:0] NV_ALTO    = 3'b111;

  // A physically consistent tank reading: every sensor below a wet one is wet.
  function automatic logic nivel_valido(input logic [2:0] nivel);
    return (nivel == NV_CRITICO) || (nivel == NV_BAIXO) ||
           (nivel == NV_MEDIO)   || (nivel == NV_ALTO);
  endfunction

  // Elaboration-time maximum, used to size the shared timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/filtro_sensor.sv
// Sensor conditioning for the tank level inputs: a two-flop synchronizer
// followed by a debouncer. The filtered vector only takes a new value once
// the synchronized vector has held steady for DEB_CYCLES consecutive cycles.
module filtro_sensor #(
  parameter int DEB_CYCLES = 4,
  parameter int W          = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] filt
);

  localparam int            CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_CNT  = CW'(DEB_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  logic [W-1:0]  sync1, sync2;
  logic [W-1:0]  cand;
  logic [CW-1:0] cnt;

  // Two-stage synchronizer for the asynchronous sensor lines.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Stability counter: any change restarts the count with the new candidate;
  // the candidate is accepted on its DEB_CYCLES-th consecutive cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= '0;
      cnt  <= '0;
      filt <= '0;
    end else if (sync2 != cand) begin
      cand <= sync2;
      cnt  <= CW'(1);
      if (DEB_CYCLES == 1) filt <= sync2;
    end else if (cnt != DEB_CNT) begin
      cnt <= cnt + 1'b1;
      if (cnt == DEB_LAST) filt <= cand;
    end
  end

endmodule

// File: rtl/controle_rega.sv
// Tank fill / irrigation controller. Filtered level sensors and a soil-dry
// request drive a five-state Moore FSM controlling the inlet valve (Ve) and
// the irrigation pump (Bomba), with forced pauses, error lockout and alarm.
// Optional build macro: CONTROLE_REGA_TIMEOUT_EN enables the fill timeout
// (ENCHE -> ERRO after T_ENCHE cycles without reaching the high level).
module controle_rega
  import rega_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int T_REGA     = 1000,
  parameter int T_PAUSA    = 200,
  parameter int T_ENCHE    = 5000
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       H,
  input  logic       M,
  input  logic       L,
  input  logic       Seco,
  input  logic       Clr_err,
  output logic       Ve,
  output logic       Bomba,
  output logic       Al,
  output logic       Err,
  output logic [2:0] Estado
);

`ifdef CONTROLE_REGA_TIMEOUT_EN
  localparam int T_MAX = max_int(max_int(T_REGA, T_PAUSA), T_ENCHE);
`else
  localparam int T_MAX = max_int(T_REGA, T_PAUSA);
`endif
  localparam int            TW       = $clog2(T_MAX) + 1;
  localparam logic [TW-1:0] LD_REGA  = TW'(T_REGA - 1);
  localparam logic [TW-1:0] LD_PAUSA = TW'(T_PAUSA - 1);
`ifdef CONTROLE_REGA_TIMEOUT_EN
  localparam logic [TW-1:0] LD_ENCHE = TW'(T_ENCHE - 1);
`else
  // T_ENCHE has no function in this build; keep the parameter referenced.
  logic unused_t_enche;
  assign unused_t_enche = ^32'(T_ENCHE);
`endif

  logic [1:0]    rst_ff;
  logic          rst_sync_n;
  logic [2:0]    nivel;
  estado_t       state, next_state;
  logic [TW-1:0] timer, timer_ld;
  logic          al_q;
  logic          nv_enche, nv_alto;

  // Reset synchronizer: assertion passes straight through, release is
  // aligned to Clk so no flop leaves reset on a marginal edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) rst_ff <= 2'b00;
    else        rst_ff <= {rst_ff[0], 1'b1};
  end
  assign rst_sync_n = rst_ff[1];

  filtro_sensor #(
    .DEB_CYCLES (DEB_CYCLES),
    .W          (3)
  ) u_filtro (
    .clk   (Clk),
    .rst_n (rst_sync_n),
    .raw   ({H, M, L}),
    .filt  (nivel)
  );

  assign nv_enche = (nivel == NV_CRITICO) || (nivel == NV_BAIXO);
  assign nv_alto  = (nivel == NV_ALTO);

  // Next-state decode; an inconsistent sensor reading overrides everything.
  // NOTE: next_state gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    if (!nivel_valido(nivel)) begin
      next_state = ERRO;
    end else begin
      case (state)
        IDLE: begin
          if (nv_enche)  next_state = ENCHE;
          else if (Seco) next_state = REGA;
        end
        ENCHE: begin
          if (nv_alto) next_state = IDLE;
`ifdef CONTROLE_REGA_TIMEOUT_EN
          else if (timer == '0) next_state = ERRO;
`endif
        end
        REGA: begin
          if (nv_enche)           next_state = ENCHE;
          else if (!Seco)         next_state = IDLE;
          else if (timer == '0)   next_state = PAUSA;
        end
        PAUSA: begin
          if (timer == '0) next_state = IDLE;
        end
        ERRO: begin
          if (Clr_err) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Timer reload value for the state being entered.
  always_comb begin
    timer_ld = '0;
    case (next_state)
      REGA:    timer_ld = LD_REGA;
      PAUSA:   timer_ld = LD_PAUSA;
`ifdef CONTROLE_REGA_TIMEOUT_EN
      ENCHE:   timer_ld = LD_ENCHE;
`endif
      default: timer_ld = '0;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge rst_sync_n) begin
    if (!rst_sync_n) state <= IDLE;
    else             state <= next_state;
  end

  // Shared down-counter: reloaded on every state change, holds at zero.
  always_ff @(posedge Clk or negedge rst_sync_n) begin
    if (!rst_sync_n)               timer <= '0;
    else if (next_state != state)  timer <= timer_ld;
    else if (timer != '0)          timer <= timer - 1'b1;
  end

  // Alarm register, updated alongside the state so Al and Err line up.
  always_ff @(posedge Clk or negedge rst_sync_n) begin
    if (!rst_sync_n) al_q <= 1'b0;
    else             al_q <= (nivel == NV_CRITICO) || (next_state == ERRO);
  end

  // Moore outputs; Ve and Bomba decode disjoint states so they never overlap.
  assign Ve     = (state == ENCHE);
  assign Bomba  = (state == REGA);
  assign Err    = (state == ERRO);
  assign Al     = al_q;
  assign Estado = state;

endmodule

// File: doc/controle_rega.md
CONTROLE_REGA -- requirements
Module: controle_rega

Interface
REQ-001 Parameter DEB_CYCLES, default 4: number of consecutive stable cycles required to accept a new sensor vector.
REQ-002 Parameter T_REGA, default 1000: maximum cycles of continuous irrigation before a forced pause.
REQ-003 Parameter T_PAUSA, default 200: number of cycles in a forced pause.
REQ-004 Parameter T_ENCHE, default 5000: fill timeout in cycles.
REQ-005 Port Clk, input, 1 bit: single clock, rising edge.
REQ-006 Port Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Ports H, M, L, input, 1 bit each: raw asynchronous tank level sensors (high, medium, low).
REQ-008 Port Seco, input, 1 bit: soil-dry irrigation request, level-sensitive, synchronous.
REQ-009 Port Clr_err, input, 1 bit: single-cycle error clear pulse.
REQ-010 Port Ve, output, 1 bit: tank inlet valve open.
REQ-011 Port Bomba, output, 1 bit: irrigation pump on.
REQ-012 Port Al, output, 1 bit: alarm.
REQ-013 Port Err, output, 1 bit: controller in error lockout.
REQ-014 Port Estado, output, 3 bits: current FSM state encoding.

Function
REQ-015 H, M, L shall pass through a two-flop synchronizer.
REQ-016 The filtered vector {H,M,L} shall update on the cycle in which the synchronized vector has been unchanged for DEB_CYCLES consecutive cycles; any change shall restart the count.
REQ-017 Filtered codes shall decode as follows: 000 = critical, 001 = low, 011 = medium, 111 = high; any other code (M&!L or H&!M) is invalid.
REQ-018 The FSM shall have exactly the states IDLE=0, ENCHE=1, REGA=2, PAUSA=3, ERRO=4. Outputs are Moore-decoded from the state register, so they respond one cycle after the filtered condition.
REQ-019 An invalid filtered code in any state shall force ERRO next cycle; this has priority over every other transition.
REQ-020 IDLE shall go to ENCHE if the level is critical or low; otherwise it shall go to REGA if Seco=1 and the level is medium or high. Fill takes priority over simultaneous Seco.
REQ-021 ENCHE shall drive Ve=1 and go to IDLE when the level is high.
REQ-022 REGA shall drive Bomba=1.
- It shall go to ENCHE if the level falls to low or critical.
- Otherwise it shall go to IDLE if Seco=0.
- Otherwise it shall go to PAUSA after T_REGA cycles in REGA.
REQ-023 PAUSA shall drive Ve=0 and Bomba=0 for T_PAUSA cycles, then go to IDLE. Seco is ignored during PAUSA.
REQ-024 ERRO shall drive Ve=0, Bomba=0 and Err=1. It shall go to IDLE only on Clr_err=1 while the filtered code is valid; Clr_err in any other state shall be ignored.
REQ-025 Ve and Bomba shall never be 1 in the same cycle.
REQ-026 Al shall equal (level is critical) OR (state is ERRO), registered.
REQ-027 One shared down-counter shall be used, reloaded on every state entry; its width shall be $clog2 of the largest enabled timing parameter plus 1. Terminal count is 0, and the counter shall not wrap.

Reset
REQ-028 While Rst_n=0, the block shall hold:
- state IDLE, Estado=0;
- Ve=Bomba=Al=Err=0;
- synchronizer and filtered vector = 000;
- debounce count and timer = 0.
REQ-029 Deassertion of Rst_n shall be synchronized to Clk. Reset asserted mid-fill or mid-irrigation shall drop Ve and Bomba immediately and asynchronously.

Configuration
REQ-030 With CONTROLE_REGA_TIMEOUT_EN defined, ENCHE shall go to ERRO if the level is not high after T_ENCHE cycles.
REQ-031 Without CONTROLE_REGA_TIMEOUT_EN, ENCHE shall have no timeout and the T_ENCHE parameter shall be unused and excluded from counter sizing.

Structure
REQ-032 Package rega_pkg shall hold:
- the state enum typedef;
- the level code localparams (NV_CRITICO, NV_BAIXO, NV_MEDIO, NV_ALTO);
- a function that checks level code validity.
REQ-033 Synchronization and debouncing shall live in a sub-module filtro_sensor, parameterized by DEB_CYCLES and 3 bits wide. The FSM, timer and outputs shall live in controle_rega.

Verification
REQ-034 Scenario 1: reset released, filtered level 001 -> Ve=1 and Estado=1 by sync+DEB+1 cycles; apply 111 -> Ve=0 and Estado=0 after the debounce.
REQ-035 Scenario 2: level 011 and Seco=1 -> Bomba=1; hold Seco=1 for T_REGA cycles -> Estado=3 and Bomba=0 for exactly T_PAUSA cycles, then Bomba=1 again.
REQ-036 Scenario 3: during REGA, level drops to 001 -> next state ENCHE, with Bomba=0 and Ve=1 and no overlap cycle.
REQ-037 Scenario 4: apply 010 for DEB_CYCLES cycles -> Err=1, Al=1, Estado=4. Clr_err while 010 persists -> remain in ERRO. Restore 011 then pulse Clr_err -> IDLE.
REQ-038 Scenario 5: glitch H for DEB_CYCLES-1 cycles -> filtered vector unchanged and no state change.
REQ-039 Scenario 6: with the macro defined, hold 001 for T_ENCHE cycles -> ERRO. Without the macro -> still ENCHE. Assert Rst_n=0 mid-ENCHE -> Ve=0 without waiting for a clock edge.
